// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_pkg
//  Description : Shared constants for the data-bus responder: MMIO register
//                offsets, STATUS bit positions and the default MMIO base.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_bus_pkg;

    // Word offsets inside the MMIO window (address[3:2])
    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_GPIO   = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // STATUS register bit positions
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_COUNT = 2;
    localparam int STAT_OVF   = 5;

    // Count field may occupy at most bits [4:2] so it never collides with OVF
    localparam int STAT_COUNT_MAX_BITS = STAT_OVF - STAT_COUNT;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

endpackage
`default_nettype wire

// File: rtl/data_bus_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous FIFO for the TX stream. Head word is presented
//                combinationally from storage; a push into a full FIFO is
//                dropped unless a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & full_o & ~do_pop;
    // Head reads zero while empty so stale storage never leaks out
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy next-state from the accepted push/pop pair
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array: data only, pointers define validity so no reset needed
    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_responder
//  Description : Data-memory responder for the single-cycle core. Word RAM
//                with combinational read and clocked write, plus an MMIO
//                window holding a cycle counter, GPIO register, TX FIFO push
//                port and a STATUS register with a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_memory,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] gpio_out,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW       = $clog2(RAM_WORDS);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_BITS = (CW > STAT_COUNT_MAX_BITS) ? STAT_COUNT_MAX_BITS : CW;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [31:0]   cycle_q;
    logic [31:0]   gpio_q;
    logic          overflow_q;

    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [1:0]    mmio_off;
    logic          wr_gpio;
    logic          wr_tx;
    logic          wr_status;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_drop;
    logic [31:0]   status_word;

    // Byte-lane bits are meaningless for a word bus
    logic          unused_byte_lane;
    assign unused_byte_lane = ^address[1:0];

    // RAM occupies the bottom 4*RAM_WORDS bytes; RAM wins if windows overlap
    assign ram_hit   = (address[31:AW+2] == '0);
    assign ram_idx   = address[AW+1:2];
    assign mmio_hit  = ~ram_hit & (address[31:4] == MMIO_BASE[31:4]);
    assign mmio_off  = address[3:2];
    assign wr_gpio   = write_memory & mmio_hit & (mmio_off == OFF_GPIO);
    assign wr_tx     = write_memory & mmio_hit & (mmio_off == OFF_TXDATA);
    assign wr_status = write_memory & mmio_hit & (mmio_off == OFF_STATUS);

    assign gpio_out = gpio_q;
    assign tx_valid = ~fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (wr_tx),
        .pop_i   (tx_valid & tx_ready),
        .data_i  (write_data),
        .data_o  (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    // STATUS assembly from live FIFO state; unassigned bits read zero
    always_comb begin
        status_word                         = '0;
        status_word[STAT_FULL]              = fifo_full;
        status_word[STAT_EMPTY]             = fifo_empty;
        status_word[STAT_COUNT +: CNT_BITS] = fifo_count[CNT_BITS-1:0];
        status_word[STAT_OVF]               = overflow_q;
    end

    // Load mux: RAM, MMIO registers, or zero for unmapped / write-only
    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = ram_q[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                OFF_CYCLE:  read_data = cycle_q;
                OFF_GPIO:   read_data = gpio_q;
                OFF_STATUS: read_data = status_word;
                default:    read_data = '0;
            endcase
        end
    end

    // RAM write port; contents intentionally survive reset
    always_ff @(posedge clock) begin
        if (write_memory && ram_hit) begin
            ram_q[ram_idx] <= write_data;
        end
    end

    // Free-running cycle counter, GPIO register and sticky overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q    <= '0;
            gpio_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (wr_gpio) begin
                gpio_q <= write_data;
            end
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end else if (wr_status && write_data[STAT_OVF]) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
